// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

  // Soft-clear engine state.
  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } clr_state_e;

  localparam int unsigned DefXlen  = 32;
  localparam int unsigned DefNregs = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// commit or by the soft-clear sweep.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NRegs   = DefNregs,
  parameter int unsigned AddrW   = $clog2(NRegs),
  parameter bit          ZeroReg = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             set_i,
  input  logic [AddrW-1:0] set_addr_i,
  input  logic             wr_clr_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic             sweep_i,
  input  logic [AddrW-1:0] sweep_addr_i,
  output logic [NRegs-1:0] pend_o
);

  logic [NRegs-1:0] pend_d, pend_q;

  // Next pending state; set is applied after the commit clear so a new
  // producer claimed in the same cycle wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_clr_i) begin
      pend_d[wr_addr_i] = 1'b0;
    end
    if (set_i && (set_addr_i != '0)) begin
      pend_d[set_addr_i] = 1'b1;
    end
    if (sweep_i) begin
      pend_d[sweep_addr_i] = 1'b0;
    end
    if (ZeroReg) begin
      pend_d[0] = 1'b0;
    end
  end

  // Pending bit storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, pending-write scoreboard
// and a sequential soft-clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = DefXlen,
  parameter int unsigned NREGS    = DefNregs,
  parameter int unsigned ADDRW    = $clog2(NREGS),
  parameter int unsigned NRPORTS  = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDRW-1:0]         waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [NRPORTS*ADDRW-1:0] raddr,
  output logic [NRPORTS*XLEN-1:0]  rdata,
  output logic [NRPORTS-1:0]       rpend,
  input  logic                     issue_valid,
  input  logic [ADDRW-1:0]         issue_rd,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  logic [XLEN-1:0]  regs_d [NREGS];
  logic [XLEN-1:0]  regs_q [NREGS];
  clr_state_e       state_d, state_q;
  logic [ADDRW-1:0] cnt_d, cnt_q;
  logic [NREGS-1:0] pend;
  logic             wr_ok;
  logic             issue_ok;
  logic             sweeping;

  assign sweeping = (state_q == StClear);
  assign clr_busy = sweeping;

  // Writes and issues are frozen while the sweep owns the array.
  assign wr_ok    = we && !sweeping && !(ZERO_REG && (waddr == '0));
  assign issue_ok = issue_valid && !sweeping;

  // Clear engine next state: one register per cycle, wrap back to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDRW'(NREGS - 1)) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear engine state and sweep counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage next state: normal write or sweep clear (never both).
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[waddr] = wdata;
    end
    if (sweeping) begin
      regs_d[cnt_q] = '0;
    end
  end

  // Register array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .NRegs   (NREGS),
    .AddrW   (ADDRW),
    .ZeroReg (ZERO_REG)
  ) u_scoreboard (
    .clk_i        (clk),
    .rst_ni       (reset),
    .set_i        (issue_ok),
    .set_addr_i   (issue_rd),
    .wr_clr_i     (wr_ok),
    .wr_addr_i    (waddr),
    .sweep_i      (sweeping),
    .sweep_addr_i (cnt_q),
    .pend_o       (pend)
  );

  // Per-port read mux with optional same-cycle forwarding.
  for (genvar k = 0; k < NRPORTS; k++) begin : g_rd
    logic [ADDRW-1:0] ra;
    logic             hit;
    assign ra  = raddr[k*ADDRW +: ADDRW];
    // wr_ok already excludes the sweep and writes to a hardwired x0.
    assign hit = BYPASS && wr_ok && (waddr == ra);
    assign rdata[k*XLEN +: XLEN] = (ZERO_REG && (ra == '0)) ? '0 :
                                   hit                       ? wdata : regs_q[ra];
    // A forwarded write retires the outstanding producer this cycle.
    assign rpend[k] = hit ? 1'b0 : pend[ra];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: a 3-port bypassing instance
// and a 1-port non-bypassing instance see the same write/issue/clear stream.
`timescale 1ns / 100ps
module tb_regfile_mp;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NP = 3;

  logic          clk;
  logic          reset;
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic [NP*AW-1:0] raddr;
  logic [NP*W-1:0]  rdata;
  logic [NP-1:0]    rpend;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          clr_req;
  logic          clr_busy;
  logic [W-1:0]  rdata_nb;
  logic [0:0]    rpend_nb;
  logic          clr_busy_nb;

  int checks   = 0;
  int failures = 0;
  int busy_cycles;

  regfile_mp #(
    .XLEN (W), .NREGS (32), .NRPORTS (NP), .BYPASS (1'b1), .ZERO_REG (1'b1)
  ) u_dut (
    .clk (clk), .reset (reset), .we (we), .waddr (waddr), .wdata (wdata),
    .raddr (raddr), .rdata (rdata), .rpend (rpend), .issue_valid (issue_valid),
    .issue_rd (issue_rd), .clr_req (clr_req), .clr_busy (clr_busy)
  );

  regfile_mp #(
    .XLEN (W), .NREGS (32), .NRPORTS (1), .BYPASS (1'b0), .ZERO_REG (1'b1)
  ) u_dut_nb (
    .clk (clk), .reset (reset), .we (we), .waddr (waddr), .wdata (wdata),
    .raddr (raddr[AW-1:0]), .rdata (rdata_nb), .rpend (rpend_nb),
    .issue_valid (issue_valid), .issue_rd (issue_rd), .clr_req (clr_req),
    .clr_busy (clr_busy_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    raddr[k*AW +: AW] = a;
  endtask

  function automatic logic [W-1:0] port_data(input int k);
    return rdata[k*W +: W];
  endfunction

  // Fill pattern: low nibble of the index repeated across the word.
  function automatic logic [W-1:0] fill_val(input int j);
    logic [3:0] n;
    n = j[3:0];
    return {8{n}};
  endfunction

  task automatic idle_inputs();
    we = 1'b0; issue_valid = 1'b0; clr_req = 1'b0;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Reads every register through port 0 and expects zero data and no pending.
  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      set_ra(0, AW'(i));
      #1;
      check({tag, "_data"}, port_data(0), '0);
      check({tag, "_pend"}, {31'b0, rpend[0]}, '0);
    end
  endtask

  // Pulses clr_req and counts clr_busy cycles, bounded.
  task automatic run_sweep(output int n_busy, input bit poke);
    @(negedge clk);
    clr_req = 1'b1;
    #1;
    check("busy_before_edge", {31'b0, clr_busy}, '0);
    n_busy = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      idle_inputs();
      if (poke && n == 4) begin
        // Sweep has cleared x0..x3; x9 and x31 untouched.
        we = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D; clr_req = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd2;
        set_ra(0, 5'd31); set_ra(1, 5'd9); set_ra(2, 5'd3);
      end
      if (poke && n == 10) begin
        we = 1'b1; waddr = 5'd1; wdata = 32'h0BADF00D;
      end
      #1;
      if (poke && n == 4) begin
        check("mid_x31_untouched", port_data(0), 32'hFFFFFFFF);
        check("mid_x9_no_bypass", port_data(1), 32'h99999999);
        check("mid_x3_cleared", port_data(2), 32'h0);
      end
      if (clr_busy) n_busy++;
      else if (n_busy > 0) break;
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    issue_valid = 1'b0; issue_rd = '0; clr_req = 1'b0;

    // Reset pulse.
    #7 reset = 1'b0;
    #3 reset = 1'b1;
    check("reset_busy", {31'b0, clr_busy}, '0);
    check_all_zero("reset");

    // x0 is hardwired, including in the write cycle itself.
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF; set_ra(0, 5'd0);
    #1;
    check("x0_write_cycle", port_data(0), '0);
    @(negedge clk);
    we = 1'b0;
    #1;
    check("x0_after", port_data(0), '0);

    // Fill x1..x31.
    for (int j = 1; j < 32; j++) begin
      @(negedge clk);
      we = 1'b1; waddr = AW'(j); wdata = fill_val(j);
    end
    @(negedge clk);
    we = 1'b0;
    set_ra(0, 5'd3); set_ra(1, 5'd10); set_ra(2, 5'd31);
    #1;
    check("rd_p0_x3", port_data(0), 32'h33333333);
    check("rd_p1_x10", port_data(1), 32'hAAAAAAAA);
    check("rd_p2_x31", port_data(2), 32'hFFFFFFFF);

    // Bypass vs. no bypass, sampled before the write edge.
    @(negedge clk);
    we = 1'b1; waddr = 5'd5; wdata = 32'h12345678; set_ra(0, 5'd5);
    #1;
    check("bypass_on", port_data(0), 32'h12345678);
    check("bypass_off", rdata_nb, 32'h55555555);
    @(negedge clk);
    we = 1'b0;
    #1;
    check("after_write_on", port_data(0), 32'h12345678);
    check("after_write_off", rdata_nb, 32'h12345678);

    // Scoreboard.
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd7; set_ra(0, 5'd7);
    #1;
    check("pend_not_yet", {31'b0, rpend[0]}, '0);
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    check("pend_set", {31'b0, rpend[0]}, 32'd1);
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'h70707070;
    #1;
    check("pend_masked_bypass", {31'b0, rpend[0]}, '0);
    check("pend_unmasked_nb", {31'b0, rpend_nb[0]}, 32'd1);
    @(negedge clk);
    we = 1'b0;
    #1;
    check("pend_cleared", {31'b0, rpend[0]}, '0);
    check("x7_written", port_data(0), 32'h70707070);
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd7;
    we = 1'b1; waddr = 5'd7; wdata = 32'h77777777;
    @(negedge clk);
    idle_inputs();
    #1;
    check("pend_set_wins", {31'b0, rpend[0]}, 32'd1);
    check("x7_same_cycle", port_data(0), 32'h77777777);
    write_reg(5'd5, 32'h55555555);

    // Soft clear of a full array with ignored traffic mid-sweep.
    run_sweep(busy_cycles, 1'b1);
    check("sweep_busy_cycles", 32'(busy_cycles), 32'd32);
    check_all_zero("sweep");

    // Reset ten cycles into a sweep.
    write_reg(5'd20, 32'h20202020);
    write_reg(5'd30, 32'h30303030);
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("busy_before_reset", {31'b0, clr_busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("busy_reset_async", {31'b0, clr_busy}, '0);
    set_ra(0, 5'd30);
    #1;
    check("x30_reset_async", port_data(0), '0);
    check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    run_sweep(busy_cycles, 1'b0);
    check("fresh_sweep_cycles", 32'(busy_cycles), 32'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
